// File: rtl/clz_wide_seq.sv
// Sequential leading-zero counter for a WIDTH-bit operand. It walks 32-bit slices, MSB slice first,
// through one shared CLZ32. Optional macro CLZ_EARLY_EXIT_EN stops the scan at the first nonzero slice.
module clz_wide_seq #(
  parameter  int WIDTH = 128,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);

  localparam int NSLICE = WIDTH / 32;
  localparam int IW     = $clog2(NSLICE);

`ifdef CLZ_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    acc_q;
  logic             found_q;
  logic             outValid_q;
  logic [CW-1:0]    outCount_q;
  logic             outZero_q;

  logic [5:0]       sliceClz;
  logic [CW-1:0]    acc_d;
  logic             found_d;
  logic             lastSlice;
  logic             scanEnd;

  // Binary-search CLZ over 32 bits. The result 32 means the slice is all zero.
  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [31:0] x;
    logic [5:0]  n;
    x = v;
    n = '0;
    if (x == 32'd0) begin
      n = 6'd32;
    end else begin
      if (x[31:16] == 16'd0) begin
        n[4] = 1'b1;
        x    = x << 16;
      end
      if (x[31:24] == 8'd0) begin
        n[3] = 1'b1;
        x    = x << 8;
      end
      if (x[31:28] == 4'd0) begin
        n[2] = 1'b1;
        x    = x << 4;
      end
      if (x[31:30] == 2'd0) begin
        n[1] = 1'b1;
        x    = x << 2;
      end
      if (!x[31]) begin
        n[0] = 1'b1;
      end
    end
    return n;
  endfunction

  always_comb begin
    sliceClz  = clz32(shreg_q[WIDTH-1 -: 32]);
    found_d   = found_q | ~sliceClz[5];
    acc_d     = found_q ? acc_q : acc_q + CW'(sliceClz);
    lastSlice = (idx_q == IW'(NSLICE - 1));
    scanEnd   = lastSlice || (EarlyExit && found_d);
  end

  // Once a slice with a set bit has been seen, acc_q stays frozen. The maximum it can reach is
  // 32*NSLICE, which is WIDTH, so CW bits never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      found_q    <= 1'b0;
      outValid_q <= 1'b0;
      outCount_q <= '0;
      outZero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg_q <= in_data;
            idx_q   <= '0;
            acc_q   <= '0;
            found_q <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          acc_q   <= acc_d;
          found_q <= found_d;
          shreg_q <= shreg_q << 32;
          idx_q   <= idx_q + IW'(1);
          if (scanEnd) begin
            outCount_q <= acc_d;
            outZero_q  <= (acc_d == CW'(WIDTH));
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = outValid_q;
  assign out_count = outCount_q;
  assign out_zero  = outZero_q;

endmodule

// File: tb/tb_clz_wide_seq.sv
// Self-checking bench for clz_wide_seq (WIDTH=128). It uses a table of fixed vectors, hand sequences
// for stall and reset, and random back-to-back traffic checked against a bit-level reference count.
module tb_clz_wide_seq;

  localparam int WIDTH  = 128;
  localparam int NSLICE = WIDTH / 32;
  localparam int CW     = $clog2(WIDTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_zero;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int prevAccept;
  int prevS;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               count;
  } vec_t;

  vec_t vecs[7];

  clz_wide_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: scan bits from the top, one at a time.
  function automatic int refClz(input logic [WIDTH-1:0] d);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (d[i]) return WIDTH - 1 - i;
    end
    return WIDTH;
  endfunction

  // The scan length follows from the count: the first nonzero slice is count/32.
  function automatic int refScanCycles(input int count);
`ifdef CLZ_EARLY_EXIT_EN
    int s;
    s = count / 32 + 1;
    return (s > NSLICE) ? NSLICE : s;
`else
    return (count >= 0) ? NSLICE : NSLICE;
`endif
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Call this at a negedge. It performs one operation with out_ready=1 and returns at the negedge
  // after the result handshake, which is when the block is back in IDLE.
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input int expCount, input string name,
                               input bit holdValid);
    int expS;
    int lat;
    int tAcc;
    expS      = refScanCycles(expCount);
    out_ready = 1'b1;
    in_data   = data;
    in_valid  = 1'b1;
    checkOutput({name, " in_ready before accept"}, in_ready, 1);
    @(posedge clk);
    #1;
    tAcc = cyc;
    if (holdValid && prevAccept >= 0)
      checkOutput({name, " accept spacing"}, tAcc - prevAccept, prevS + 2);
    prevAccept = tAcc;
    prevS      = expS;
    if (!holdValid) in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
    checkOutput({name, " scan cycles"}, lat, expS);
    checkOutput({name, " out_count"}, out_count, expCount);
    checkOutput({name, " out_zero"}, out_zero, (expCount == WIDTH) ? 1 : 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " out_valid after handshake"}, out_valid, 0);
    checkOutput({name, " in_ready after handshake"}, in_ready, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] rnd;
    int               lat;

    vecs[0] = '{128'h00008000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 16};
    vecs[1] = '{128'h0, 128};
    vecs[2] = '{128'h00000000_00000001_00000000_00000000, 63};
    vecs[3] = '{128'h80000000_00000000_00000000_00000000, 0};
    vecs[4] = '{128'h1, 127};
    vecs[5] = '{128'h00000000_00000000_00000000_80000000, 96};
    vecs[6] = '{128'h00000000_FFFFFFFF_00000000_00000000, 32};

    prevAccept = -1;
    prevS      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_count", out_count, 0);
    checkOutput("reset out_zero", out_zero, 0);
    checkOutput("reset in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].data, vecs[i].count, $sformatf("vec%0d", i), 1'b0);

    $display("[TB] stalled consumer");
    out_ready = 1'b0;
    in_data   = 128'h00000000_00000000_00000100_00000000;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
    checkOutput("stall out_valid rises", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 128'hFFFFFFFF_00000000_00000000_00000000;
      @(negedge clk);
      checkOutput($sformatf("stall%0d out_valid", i), out_valid, 1);
      checkOutput($sformatf("stall%0d out_count", i), out_count, 87);
      checkOutput($sformatf("stall%0d out_zero", i), out_zero, 0);
      checkOutput($sformatf("stall%0d in_ready", i), in_ready, 0);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall release out_valid", out_valid, 0);
    checkOutput("stall release in_ready", in_ready, 1);
    checkOutput("stall release out_count held", out_count, 87);
    repeat (6) @(negedge clk);
    checkOutput("stall no phantom op", out_valid, 0);

    $display("[TB] reset mid-scan and while pending");
    in_data  = 128'h0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midscan in_ready busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midscan reset in_ready", in_ready, 1);
    checkOutput("midscan reset out_valid", out_valid, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    in_data   = 128'h04000000_00000000_00000000_00000000;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
    checkOutput("pending out_count", out_count, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("pending reset out_valid", out_valid, 0);
    checkOutput("pending reset out_count", out_count, 0);
    checkOutput("pending reset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(128'h1, 127, "post-reset", 1'b0);

    $display("[TB] random back-to-back");
    prevAccept = -1;
    for (int i = 0; i < 40; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      rnd = rnd >> $urandom_range(0, WIDTH);
      applyStimulus(rnd, refClz(rnd), $sformatf("rnd%0d", i), 1'b1);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
